// File: rtl/sar_logic.sv
// sar_logic: control logic for a 16-bit successive-approximation ADC.
// Sequence: sample the input, then test one bit per comparator strobe from
// the MSB down to the LSB, then publish the result on dout with a done pulse.
// Optional feature macro: SAR_CONTINUOUS_EN adds the cont_mode input. When
// cont_mode is high, a finished conversion goes straight back to sampling.
module sar_logic #(
  parameter int SAMPLE_CYCLES = 4,  // cycles with the sampling switch closed (1..255)
  parameter int COMP_WAIT     = 1   // cycles from strobe to comparator sample (1..15)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        comp_out,
`ifdef SAR_CONTINUOUS_EN
  input  logic        cont_mode,
`endif
  output logic        samp,
  output logic        comp_trig,
  output logic [15:0] cap_botplate_m,
  output logic [15:0] cap_botplate_d,
  output logic [15:0] dout,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] SAMP_LOAD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(COMP_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TRIG,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e      state_q;
  logic [7:0]  samp_cnt_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  bit_idx_q;
  logic [15:0] trial_q;
  logic [15:0] dout_q;
  logic        samp_q;
  logic        comp_trig_q;
  logic        busy_q;
  logic        done_q;

  // Bit-decision helpers: the bit under test, the next lower bit to try,
  // and the trial word with the current bit kept or dropped.
  logic [15:0] bit_mask;
  logic [15:0] next_mask;
  logic [15:0] decided_trial;
  logic        restart;

  assign bit_mask      = 16'h0001 << bit_idx_q;
  assign next_mask     = bit_mask >> 1;  // zero once the LSB has been decided
  assign decided_trial = comp_out ? trial_q : (trial_q & ~bit_mask);

`ifdef SAR_CONTINUOUS_EN
  assign restart = cont_mode;
`else
  assign restart = 1'b0;
`endif

  // Conversion sequencer: state, counters, trial word and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      samp_cnt_q  <= 8'd0;
      wait_cnt_q  <= 4'd0;
      bit_idx_q   <= 4'd15;
      trial_q     <= 16'h0000;
      dout_q      <= 16'h0000;
      samp_q      <= 1'b0;
      comp_trig_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_SAMPLE;
            samp_q     <= 1'b1;
            busy_q     <= 1'b1;
            samp_cnt_q <= SAMP_LOAD;
          end
        end
        ST_SAMPLE: begin
          if (samp_cnt_q == 8'd0) begin
            // Open the switch and present the MSB trial to the DAC together
            // with the first comparator strobe.
            state_q     <= ST_TRIG;
            samp_q      <= 1'b0;
            trial_q     <= 16'h8000;
            bit_idx_q   <= 4'd15;
            comp_trig_q <= 1'b1;
          end else begin
            samp_cnt_q <= samp_cnt_q - 8'd1;
          end
        end
        ST_TRIG: begin
          state_q     <= ST_WAIT;
          comp_trig_q <= 1'b0;
          wait_cnt_q  <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            if (bit_idx_q != 4'd0) begin
              trial_q     <= decided_trial | next_mask;
              bit_idx_q   <= bit_idx_q - 4'd1;
              state_q     <= ST_TRIG;
              comp_trig_q <= 1'b1;
            end else begin
              trial_q <= decided_trial;
              dout_q  <= decided_trial;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          trial_q   <= 16'h0000;
          bit_idx_q <= 4'd15;
          if (restart) begin
            state_q    <= ST_SAMPLE;
            samp_q     <= 1'b1;
            samp_cnt_q <= SAMP_LOAD;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          trial_q     <= 16'h0000;
          samp_q      <= 1'b0;
          comp_trig_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign samp           = samp_q;
  assign comp_trig      = comp_trig_q;
  assign cap_botplate_m = trial_q;
  assign cap_botplate_d = ~trial_q;  // differential plate is always the complement
  assign dout           = dout_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: doc/sar_logic.md
SAR_LOGIC -- requirements
Module: sar_logic

Interface
REQ-001 Parameter SAMPLE_CYCLES, 4, cycles the sampling switch is held closed (legal 1..255).
REQ-002 Parameter COMP_WAIT, 1, cycles between comp_trig and sampling comp_out (legal 1..15).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  conversion request, sampled only in IDLE.
REQ-007 comp_out  input  1  comparator decision, synchronous to clk; 1 = keep trial bit.
REQ-008 samp  output  1  sampling-switch control, drives top-plate sampling switch.
REQ-009 comp_trig  output  1  one-cycle comparator strobe.
REQ-010 cap_botplate_m  output  16  main-cap bottom-plate drive, equals trial register.
REQ-011 cap_botplate_d  output  16  diff-cap bottom-plate drive, equals bitwise inverse of trial register.
REQ-012 dout  output  16  last completed conversion result.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when dout updates.

Function
REQ-015 FSM states: IDLE, SAMPLE, TRIG, WAIT, DONE; all outputs registered.
REQ-016 IDLE: samp=0, comp_trig=0, trial=16'h0000; start=1 at edge N -> SAMPLE, samp=1 from edge N.
REQ-017 SAMPLE: held exactly SAMPLE_CYCLES cycles; at exit edge samp=0, trial=16'h8000, bit index=15, -> TRIG.
REQ-018 TRIG: comp_trig=1 for exactly one cycle, -> WAIT.
REQ-019 WAIT: held COMP_WAIT cycles; on final WAIT edge comp_out sampled: bit[index] kept if 1, cleared if 0; if index>0, bit[index-1] set, index decremented, -> TRIG; if index=0 -> DONE.
REQ-020 DONE entry edge: dout <= final trial, done=1 for one cycle; next edge -> IDLE, trial=16'h0000.
REQ-021 Latency: done high in cycle beginning at edge N+SAMPLE_CYCLES+16*(1+COMP_WAIT) (N+36 at defaults).
REQ-022 start in any state other than IDLE is ignored; no queuing.
REQ-023 start held high continuously yields back-to-back conversions, one IDLE cycle between done and next samp.
REQ-024 comp_out ignored outside final WAIT cycle.
REQ-025 cap_botplate_d == ~cap_botplate_m in every cycle, including reset.
REQ-026 dout holds its value between conversions; changes only at DONE entry or reset.

Reset
REQ-027 rst=1 at any edge, including mid-conversion: state=IDLE, trial=16'h0000 (d=16'hFFFF), dout=16'h0000, samp=0, comp_trig=0, busy=0, done=0, index=15.
REQ-028 rst has priority over start and comp_out; start with rst high is discarded.

Configuration
REQ-029 Macro SAR_CONTINUOUS_EN defined: adds input cont_mode (1 bit); cont_mode=1 at DONE -> SAMPLE directly (samp=1 at next edge), skipping IDLE; start ignored while cont_mode=1 loop runs.
REQ-030 SAR_CONTINUOUS_EN undefined: cont_mode port absent; DONE always -> IDLE.

Verification
REQ-031 Reset: rst high 3 cycles -> cap_botplate_m=16'h0000, cap_botplate_d=16'hFFFF, dout=0, samp=busy=done=comp_trig=0.
REQ-032 comp_out tied 1, start pulse at edge N -> dout=16'hFFFF, done only at N+36, 16 comp_trig pulses.
REQ-033 comp_out tied 0 -> dout=16'h0000; m sequence 8000,4000,2000,...,0001.
REQ-034 Comparator model comp_out=(trial<=16'hA5C3) -> dout=16'hA5C3; first trials 8000,C000,A000,B000.
REQ-035 start re-pulsed mid-conversion ignored; rst at bit 8 -> all reset values next cycle; following start -> correct result at N+36.
REQ-036 SAR_CONTINUOUS_EN, cont_mode=1 -> samp rises cycle after done; second done exactly 37 cycles after first.
